// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_bridge
// Description : Address decoder between the CPU core memory port, a
//               synchronous block RAM and a small page of memory-mapped I/O
//               registers (servo PWM generator, synchronized IR inputs, IR
//               output latch). Read data is returned exactly one clock after
//               the address for every region; the bridge never stalls.
// Ports       :
//   clk         system clock
//   rst         asynchronous, active-high reset
//   core_addr   24-bit word address from the core
//   core_wdata  16-bit write data from the core
//   core_we     write strobe from the core
//   core_rdata  16-bit read data to the core (one clock after the address)
//   ram_addr    block RAM word address (pass-through)
//   ram_wdata   block RAM write data (pass-through)
//   ram_we      block RAM write enable
//   ram_rdata   block RAM read data, valid one clock after ram_addr
//   ir_in       asynchronous IR sensor inputs
//   ir_out      IR emitter enables
//   servo_out   servo PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_bridge #(
  parameter int          RAM_AW     = 14,
  parameter logic [15:0] IO_PAGE    = 16'hFFFF,
  parameter int          PWM_PERIOD = 1000000,
  parameter int          SERVO_MIN  = 50000,
  parameter int          SERVO_STEP = 196
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       core_addr,
  input  logic [15:0]       core_wdata,
  input  logic              core_we,
  output logic [15:0]       core_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  input  logic [7:0]        ir_in,
  output logic [7:0]        ir_out,
  output logic              servo_out
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]  c_sel_none  = 2'd0;
  localparam logic [1:0]  c_sel_ram   = 2'd1;
  localparam logic [1:0]  c_sel_io    = 2'd2;

  localparam logic [7:0]  c_off_servo = 8'h00;
  localparam logic [7:0]  c_off_irin  = 8'h01;
  localparam logic [7:0]  c_off_irout = 8'h02;
  localparam logic [7:0]  c_off_frame = 8'h03;

  localparam logic [7:0]  c_servo_rst    = 8'h80;
  localparam logic [19:0] c_period_last  = 20'(PWM_PERIOD - 1);
  localparam logic [19:0] c_servo_min    = 20'(SERVO_MIN);
  localparam logic [19:0] c_servo_step   = 20'(SERVO_STEP);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic        w_in_ram;
  logic        w_in_io;
  logic [7:0]  w_offset;
  logic        w_io_wr;
  logic [15:0] w_io_rd;
  logic        w_wrap;
  logic [19:0] w_pulse_len;

  logic [1:0]  r_sel;
  logic [15:0] r_io_q;

  logic [7:0]  r_servo_pos;
  logic [7:0]  r_ir_out;
  logic [7:0]  r_ir_sync1;
  logic [7:0]  r_ir_sync2;
  logic [15:0] r_frame_cnt;

  logic [19:0] r_counter;
  logic [7:0]  r_shadow_pos;
  logic        r_servo_out;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_in_ram = (core_addr[23:RAM_AW] == '0);
  assign w_in_io  = (core_addr[23:8] == IO_PAGE);
  assign w_offset = core_addr[7:0];
  assign w_io_wr  = core_we & w_in_io;

  // --------------------------------------------------------------------------
  // RAM path: address and data are pure pass-through. The write enable is
  // gated by rst so a core write cannot land in RAM while the system is held
  // in reset.
  // --------------------------------------------------------------------------
  assign ram_addr  = core_addr[RAM_AW-1:0];
  assign ram_wdata = core_wdata;
  assign ram_we    = core_we & w_in_ram & ~rst;

  // --------------------------------------------------------------------------
  // I/O read mux, evaluated on the pre-edge register values so that a read
  // coinciding with a write to the same register returns the old contents.
  // --------------------------------------------------------------------------
  always_comb begin
    w_io_rd = '0;
    case (w_offset)
      c_off_servo: w_io_rd = {8'h00, r_servo_pos};
      c_off_irin:  w_io_rd = {8'h00, r_ir_sync2};
      c_off_irout: w_io_rd = {8'h00, r_ir_out};
      c_off_frame: w_io_rd = r_frame_cnt;
      default:     w_io_rd = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read-return stage: region select and I/O data are captured every clock,
  // which lines the I/O path up with the one-clock RAM read latency.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel  <= c_sel_none;
      r_io_q <= '0;
    end else begin
      if (w_in_ram) begin
        r_sel <= c_sel_ram;
      end else if (w_in_io) begin
        r_sel <= c_sel_io;
      end else begin
        r_sel <= c_sel_none;
      end
      r_io_q <= w_io_rd;
    end
  end

  // NONE (including the reset value of r_sel) forces zero, so core_rdata
  // drops to 0 as soon as rst is asserted.
  always_comb begin
    core_rdata = '0;
    case (r_sel)
      c_sel_ram: core_rdata = ram_rdata;
      c_sel_io:  core_rdata = r_io_q;
      default:   core_rdata = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Writable I/O registers. Only bits [7:0] of the write data are stored;
  // writes to read-only or unmapped offsets fall through and are dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_servo_pos <= c_servo_rst;
      r_ir_out    <= '0;
    end else if (w_io_wr) begin
      case (w_offset)
        c_off_servo: r_servo_pos <= core_wdata[7:0];
        c_off_irout: r_ir_out    <= core_wdata[7:0];
        default:     ;
      endcase
    end
  end

  assign ir_out = r_ir_out;

  // --------------------------------------------------------------------------
  // IR input two-flop synchronizer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir_sync1 <= '0;
      r_ir_sync2 <= '0;
    end else begin
      r_ir_sync1 <= ir_in;
      r_ir_sync2 <= r_ir_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Servo PWM
  // The position used for a frame lives in r_shadow_pos, which is only
  // reloaded at the frame wrap, so a mid-frame SERVO_POS write never disturbs
  // the pulse in progress. The pulse length follows the shadow directly, so
  // the first frame after reset already uses the reset position.
  // --------------------------------------------------------------------------
  assign w_wrap      = (r_counter == c_period_last);
  assign w_pulse_len = c_servo_min + ({12'h000, r_shadow_pos} * c_servo_step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_counter    <= '0;
      r_shadow_pos <= c_servo_rst;
      r_frame_cnt  <= '0;
    end else if (w_wrap) begin
      r_counter    <= '0;
      r_shadow_pos <= r_servo_pos;
      r_frame_cnt  <= r_frame_cnt + 16'd1;
    end else begin
      r_counter    <= r_counter + 20'd1;
    end
  end

  // Registered comparison keeps the output glitch-free; it trails the
  // counter by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_servo_out <= 1'b0;
    end else begin
      r_servo_out <= (r_counter < w_pulse_len);
    end
  end

  assign servo_out = r_servo_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_bridge
// Description : Self-checking bench for mem_io_bridge. A short PWM frame is
//               used so several complete frames fit in a short run:
//               period 400, min 20, step 1 -> pos 0x80 = 148, 0xFF = 275.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_bridge;

  localparam int c_ram_aw = 14;
  localparam int c_period = 400;
  localparam int c_min    = 20;
  localparam int c_step   = 1;

  logic                clk;
  logic                rst;
  logic [23:0]         core_addr;
  logic [15:0]         core_wdata;
  logic                core_we;
  logic [15:0]         core_rdata;
  logic [c_ram_aw-1:0] ram_addr;
  logic [15:0]         ram_wdata;
  logic                ram_we;
  logic [15:0]         ram_rdata;
  logic [7:0]          ir_in;
  logic [7:0]          ir_out;
  logic                servo_out;

  int n_checks = 0;
  int n_err    = 0;

  mem_io_bridge #(
    .RAM_AW    (c_ram_aw),
    .IO_PAGE   (16'hFFFF),
    .PWM_PERIOD(c_period),
    .SERVO_MIN (c_min),
    .SERVO_STEP(c_step)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_we   (core_we),
    .core_rdata(core_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .ir_in     (ir_in),
    .ir_out    (ir_out),
    .servo_out (servo_out)
  );

  // Synchronous block RAM model: one-clock read latency.
  logic [15:0] mem [0:(1<<c_ram_aw)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        exp_ram_we;
    logic        chk;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [23:0] a, input logic [15:0] d, input logic w);
    core_addr  = a;
    core_wdata = d;
    core_we    = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until servo_out reaches lvl, bounded.
  task automatic wait_level(input logic lvl, input string name);
    for (int g = 0; g < 2000; g++) begin
      if (servo_out === lvl) return;
      tick();
    end
    n_checks++;
    n_err++;
    $display("FAIL %s: got no servo level %0d required within 2000 clks", name, lvl);
  endtask

  // Count clocks servo_out stays high; optionally writes SERVO_POS=0xFF
  // ten clocks into the pulse.
  task automatic measure_high(output int w, input bit wr_pos);
    w = 0;
    while (servo_out === 1'b1 && w < 2000) begin
      if (wr_pos && w == 10)      drive(24'hFFFF00, 16'h00FF, 1'b1);
      else if (wr_pos && w == 11) drive(24'h000000, 16'h0000, 1'b0);
      tick();
      w++;
    end
  endtask

  task automatic measure_low(output int w);
    w = 0;
    while (servo_out === 1'b0 && w < 2000) begin
      tick();
      w++;
    end
  endtask

  initial begin
    int hi;
    int lo;
    int first;
    int bad;
    logic [15:0] fa;
    logic [15:0] fb;

    //            addr        wdata     we    ramwe chk   exp_rd
    vecs[0]  = '{24'h002800, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{24'h002800, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    vecs[2]  = '{24'h003FFF, 16'h1357, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{24'h003FFF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1357};
    vecs[4]  = '{24'h004000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[5]  = '{24'hFFFF02, 16'h00A5, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[6]  = '{24'hFFFF02, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A5};
    vecs[7]  = '{24'hFFFF01, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[8]  = '{24'hFFFF01, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[9]  = '{24'hFFFF00, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0080};
    vecs[10] = '{24'h800000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[11] = '{24'hFFFF7F, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[12] = '{24'h800000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[13] = '{24'hFFFF00, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0080};
    vecs[14] = '{24'hFFFE02, 16'h0055, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[15] = '{24'hFFFF02, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A5};
    vecs[16] = '{24'h002800, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    vecs[17] = '{24'hFFFF03, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};

    rst   = 1'b1;
    ir_in = 8'h00;
    drive(24'h000000, 16'h0000, 1'b0);
    #1;
    check("reset servo_out", {31'd0, servo_out}, 32'd0);
    check("reset core_rdata", {16'd0, core_rdata}, 32'd0);
    check("reset ir_out", {24'd0, ir_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First frame after reset uses position 0x80.
    tick();
    measure_high(hi, 1'b0);
    check("first pulse width", hi, c_min + 128 * c_step);
    measure_low(lo);
    check("first frame period", hi + lo, c_period);

    // Directed access table.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      #1;
      check($sformatf("vec%0d ram_we", i), {31'd0, ram_we}, {31'd0, vecs[i].exp_ram_we});
      check($sformatf("vec%0d ram_addr", i), {18'd0, ram_addr}, {18'd0, vecs[i].addr[c_ram_aw-1:0]});
      tick();
      if (vecs[i].chk)
        check($sformatf("vec%0d rdata", i), {16'd0, core_rdata}, {16'd0, vecs[i].exp_rd});
    end
    check("ir_out latch", {24'd0, ir_out}, 32'h0000_00A5);

    // IR input synchronizer latency.
    drive(24'hFFFF01, 16'h0000, 1'b0);
    tick();
    tick();
    #3 ir_in = 8'h3C;
    first = -1;
    bad   = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (core_rdata == 16'h003C && first < 0) first = k;
      if (core_rdata != 16'h003C && core_rdata != 16'h0000) bad++;
    end
    check("ir_in latency ok", {31'd0, (first >= 1 && first <= 3)}, 32'd1);
    check("ir_in clean values", bad, 0);
    check("ir_in final", {16'd0, core_rdata}, 32'h0000_003C);

    // Mid-frame SERVO_POS write: current pulse unchanged, next uses 0xFF.
    drive(24'h000000, 16'h0000, 1'b0);
    wait_level(1'b0, "align low");
    wait_level(1'b1, "align high");
    measure_high(hi, 1'b1);
    check("pulse during write", hi, c_min + 128 * c_step);
    measure_low(lo);
    check("frame period", hi + lo, c_period);
    measure_high(hi, 1'b0);
    check("pulse after write", hi, c_min + 255 * c_step);

    // FRAME_CNT advances by exactly one per frame period.
    drive(24'hFFFF03, 16'h0000, 1'b0);
    tick();
    fa = core_rdata;
    repeat (c_period) tick();
    fb = core_rdata;
    check("frame_cnt step", {16'd0, fb - fa}, 32'd1);

    // Asynchronous reset in the middle of a pulse.
    drive(24'hFFFF02, 16'h0000, 1'b0);
    tick();
    wait_level(1'b0, "rst align low");
    wait_level(1'b1, "rst align high");
    check("pre-reset rdata", {16'd0, core_rdata}, 32'h0000_00A5);
    #2;
    rst = 1'b1;
    drive(24'h000010, 16'h1111, 1'b1);
    #1;
    check("async rst servo_out", {31'd0, servo_out}, 32'd0);
    check("async rst rdata", {16'd0, core_rdata}, 32'd0);
    check("rst gates ram_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(24'hFFFF00, 16'h0000, 1'b0);
    check("post-rst ir_out", {24'd0, ir_out}, 32'd0);
    tick();
    check("post-rst servo_pos", {16'd0, core_rdata}, 32'h0000_0080);
    drive(24'hFFFF03, 16'h0000, 1'b0);
    tick();
    check("post-rst frame_cnt", {16'd0, core_rdata}, 32'd0);
    drive(24'hFFFF02, 16'h0000, 1'b0);
    tick();
    check("post-rst ir_out read", {16'd0, core_rdata}, 32'd0);

    // Upper data bits of SERVO_POS are not stored.
    drive(24'hFFFF00, 16'hFF34, 1'b1);
    tick();
    drive(24'hFFFF00, 16'h0000, 1'b0);
    tick();
    check("servo_pos upper bits", {16'd0, core_rdata}, 32'h0000_0034);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
Sits directly downstream of the CPU core's memory port and decodes every core access (24-bit word address, 16-bit data). Low addresses go to a synchronous block RAM. The top 256-word page goes to memory-mapped I/O registers: a servo PWM generator, a synchronized IR sensor input and an IR output latch. Read data always returns exactly one cycle after the address, matching the core's fetch→decode and load1→load2 timing.

Parameters:
RAM_AW, 14, RAM word-address width; RAM spans 0x000000..(2^RAM_AW)-1 and covers the reset PC 0x2800.
IO_PAGE, 16'hFFFF, core_addr[23:8] value that selects the I/O page.
PWM_PERIOD, 1000000, servo frame length in clocks (20 ms @ 50 MHz).
SERVO_MIN, 50000, pulse width in clocks for position 0.
SERVO_STEP, 196, extra pulse clocks per position LSB.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
core_addr  in  24  word address from core (mem_addr)
core_wdata  in  16  write data from core (data_from_core_to_mem)
core_we  in  1  write strobe from core (write_en)
core_rdata  out  16  read data to core (data_from_mem)
ram_addr  out  RAM_AW  block RAM address
ram_wdata  out  16  block RAM write data
ram_we  out  1  block RAM write enable
ram_rdata  in  16  block RAM read data; valid one clock after ram_addr
ir_in  in  8  asynchronous IR sensor inputs
ir_out  out  8  IR emitter enables
servo_out  out  1  servo PWM

Behaviour:
- Decode, combinational on core_addr:
  - in_ram = core_addr[23:RAM_AW]==0.
  - in_io = core_addr[23:8]==IO_PAGE.
  - Everything else is unmapped.
- RAM path:
  - ram_addr = core_addr[RAM_AW-1:0] and ram_wdata = core_wdata, both pass-through.
  - ram_we = core_we & in_ram.
  - ram_we is forced 0 while rst is high.
- I/O map (offset = core_addr[7:0]):
  - 0x00 SERVO_POS: RW, bits[7:0], upper bits read 0.
  - 0x01 IR_IN: RO, synchronized ir_in.
  - 0x02 IR_OUT: RW, bits[7:0].
  - 0x03 FRAME_CNT: RO, 16-bit count of completed PWM frames, wraps 0xFFFF→0.
  - Other offsets read 0. Writes to RO or unmapped locations are ignored.
- I/O writes happen on the clk edge where core_we=1 and in_io. There is no write acknowledge.
- Read return:
  - A select register (RAM / IO / NONE) and a registered I/O read value are captured every clock from the current address.
  - core_rdata = ram_rdata if sel==RAM, io_q if sel==IO, 0 if NONE. Latency is exactly 1 clock for all regions.
  - A read in the same cycle as a write to the same I/O register returns the old value.
- IR input: two-flop synchronizer. IR_IN reflects a pin change 2–3 clocks later.
- Servo PWM:
  - 20-bit counter runs 0..PWM_PERIOD-1, then wraps to 0.
  - On wrap: shadow_pos <= SERVO_POS, FRAME_CNT increments, and pulse_len = SERVO_MIN + shadow_pos*SERVO_STEP, computed at 20-bit width with no overflow for the defaults.
  - servo_out = 1 while counter < pulse_len. The output is registered, so one clock of latency.
  - A mid-frame SERVO_POS write never alters the frame in progress.
- Reset (async, all flops):
  - counter 0, SERVO_POS 0x80, shadow_pos 0x80, FRAME_CNT 0.
  - ir_out 0, sync flops 0, sel NONE, io_q 0, core_rdata 0, servo_out 0.
  - Reset mid-frame truncates the pulse immediately. The first frame after release uses position 0x80.
- The block holds no state machine for the core. It never stalls, and it accepts a new access every clock.

Test Plan:
- Write 0xBEEF to 0x002800, then read 0x002800 -> ram_we pulses 1 clk with ram_addr 0x2800; core_rdata=0xBEEF on the clock after the read address.
- Write 0x00A5 to 0xFFFF02, read 0xFFFF02 -> ir_out=0xA5 after the write edge; readback 0x00A5. Then write 0x1234 to 0xFFFF01 -> IR_IN unaffected, read equals synced pins.
- Drive ir_in=0x3C at an arbitrary time -> read of 0xFFFF01 returns 0x003C no later than 3 clks after the change, and never a metastable/partial value in a clean sim.
- Defaults with SERVO_POS written 0xFF mid-frame -> current frame pulse stays 50000+128*196=75088 clks; next frame pulse is 50000+255*196=99980 clks; FRAME_CNT increments by 1 per 1000000 clks.
- Read 0x800000 (unmapped) and 0xFFFF7F -> core_rdata=0x0000; write to 0x800000 -> ram_we stays 0 and no I/O register changes.
- Assert rst for 1 clk mid-pulse -> servo_out and core_rdata drop to 0 asynchronously; SERVO_POS reads 0x0080; ir_out=0; FRAME_CNT=0.
